// File: rtl/row_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// row_transfer_sequencer
//
// Sequences one matrix job:
//   1. Receive 2*MATRIX_N packets (A rows, then B columns) from the comm
//      controller and store them in row memory at addresses 0..2N-1.
//   2. Pulse the multiplier and wait until it reports the C rows are in
//      memory at addresses 2N..3N-1.
//   3. Read the C rows back one by one and hand each one to the comm
//      controller for transmission.
// A received packet whose header is 0 or larger than MATRIX_N aborts the job
// and raises a sticky error flag. The flag clears on the next accepted go.
//
// Ports
//   clk, resetn        rising-edge clock, asynchronous active-low reset
//   go                 start a job (only looked at while idle)
//   comm_op            0 = receive, 1 = transmit
//   comm_start         one-cycle request to transmit comm_tx_data
//   comm_rx_complete   comm_rx_data holds a complete received packet
//   comm_rx_data       received packet, header in the top 8*HEADER bits
//   comm_tx_complete   the comm controller has finished one transmission
//   comm_tx_data       packet to transmit
//   mem_we/addr/wdata  row memory write port and shared address
//   mem_rdata          row memory read data, one cycle after mem_addr
//   mult_start         one-cycle multiplier start
//   mult_done          multiplier finished
//   busy               high in every state except idle
//   done               one-cycle end-of-job pulse
//   error              sticky bad-header flag
//
// Every output is driven straight from a register. Each register is loaded
// from the same decision that selects the next state, so an output belongs to
// the state being entered.
// -----------------------------------------------------------------------------
module row_transfer_sequencer #(
    parameter  int MATRIX_N = 4,
    parameter  int HEADER   = 1,
    localparam int DW       = HEADER*8 + 32*MATRIX_N,
    localparam int AW       = $clog2(3*MATRIX_N)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    output logic          comm_op,
    output logic          comm_start,
    input  logic          comm_rx_complete,
    input  logic [DW-1:0] comm_rx_data,
    input  logic          comm_tx_complete,
    output logic [DW-1:0] comm_tx_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mult_start,
    input  logic          mult_done,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int CW = (2*MATRIX_N > 1) ? $clog2(2*MATRIX_N) : 1;
    localparam int HW = 8*HEADER;

    localparam logic [CW-1:0] RX_LAST = CW'(2*MATRIX_N - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(MATRIX_N - 1);
    localparam logic [AW-1:0] C_BASE  = AW'(2*MATRIX_N);
    localparam logic [HW-1:0] HDR_MAX = HW'(MATRIX_N);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RX_WAIT   = 4'd1,
        S_RX_STORE  = 4'd2,
        S_COMPUTE   = 4'd3,
        S_WAIT_MULT = 4'd4,
        S_TX_FETCH  = 4'd5,
        S_TX_LATCH  = 4'd6,
        S_TX_WAIT   = 4'd7,
        S_DONE      = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          comm_op_q, comm_op_d;
    logic          comm_start_q, comm_start_d;
    logic [DW-1:0] comm_tx_data_q, comm_tx_data_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mult_start_q, mult_start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [HW-1:0] rx_hdr_s;
    logic          rx_hdr_bad_s;

    // Header of the incoming packet and its range check (valid range 1..N).
    always_comb begin
        rx_hdr_s     = comm_rx_data[DW-1 -: HW];
        rx_hdr_bad_s = (rx_hdr_s == {HW{1'b0}}) || (rx_hdr_s > HDR_MAX);
    end

    // Next-state and next-output decode; unhandled events in a state are ignored.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        comm_op_d      = comm_op_q;
        comm_start_d   = 1'b0;
        comm_tx_data_d = comm_tx_data_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mult_start_d   = 1'b0;
        done_d         = 1'b0;
        error_d        = error_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_RX_WAIT;
                    cnt_d     = {CW{1'b0}};
                    error_d   = 1'b0;
                    comm_op_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RX_WAIT: begin
                if (comm_rx_complete) begin
                    if (rx_hdr_bad_s) begin
                        state_d   = S_ERROR;
                        error_d   = 1'b1;
                        comm_op_d = 1'b0;
                    end else begin
                        // The write strobe is issued while in RX_STORE, so it
                        // comes one cycle after rx_complete.
                        state_d     = S_RX_STORE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = AW'(cnt_q);
                        mem_wdata_d = comm_rx_data;
                    end
                end else begin
                    state_d = S_RX_WAIT;
                end
            end

            S_RX_STORE: begin
                if (cnt_q == RX_LAST) begin
                    state_d      = S_COMPUTE;
                    mult_start_d = 1'b1;
                end else begin
                    state_d = S_RX_WAIT;
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end

            S_COMPUTE: begin
                state_d = S_WAIT_MULT;
            end

            S_WAIT_MULT: begin
                if (mult_done) begin
                    state_d    = S_TX_FETCH;
                    cnt_d      = {CW{1'b0}};
                    mem_addr_d = C_BASE;
                end else begin
                    state_d = S_WAIT_MULT;
                end
            end

            S_TX_FETCH: begin
                // The address is presented during this state; the read data
                // becomes valid during TX_LATCH.
                state_d = S_TX_LATCH;
            end

            S_TX_LATCH: begin
                state_d        = S_TX_WAIT;
                comm_tx_data_d = mem_rdata;
                comm_op_d      = 1'b1;
                comm_start_d   = 1'b1;
            end

            S_TX_WAIT: begin
                if (comm_tx_complete) begin
                    if (cnt_q == TX_LAST) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        comm_op_d = 1'b0;
                    end else begin
                        state_d    = S_TX_FETCH;
                        cnt_d      = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        mem_addr_d = C_BASE + AW'(cnt_q) + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = S_TX_WAIT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERROR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, packet counter and every output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            cnt_q          <= {CW{1'b0}};
            comm_op_q      <= 1'b0;
            comm_start_q   <= 1'b0;
            comm_tx_data_q <= {DW{1'b0}};
            mem_we_q       <= 1'b0;
            mem_addr_q     <= {AW{1'b0}};
            mem_wdata_q    <= {DW{1'b0}};
            mult_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            comm_op_q      <= comm_op_d;
            comm_start_q   <= comm_start_d;
            comm_tx_data_q <= comm_tx_data_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mult_start_q   <= mult_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign comm_op      = comm_op_q;
    assign comm_start   = comm_start_q;
    assign comm_tx_data = comm_tx_data_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mult_start   = mult_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_row_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for row_transfer_sequencer (MATRIX_N=4, HEADER=1).
// The driver issues randomized jobs. For each job it pushes the events it
// expects (memory writes, mult_start, transmissions, done), together with the
// cycle each one should appear in, into queues. A separate monitor pops and
// compares whenever the DUT shows one of those events. Row memory and the
// C rows are modelled here.
// -----------------------------------------------------------------------------
module tb_row_transfer_sequencer;

    localparam int N      = 4;
    localparam int HEADER = 1;
    localparam int DW     = HEADER*8 + 32*N;
    localparam int AW     = $clog2(3*N);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          go = 1'b0;
    logic          comm_rx_complete = 1'b0;
    logic [DW-1:0] comm_rx_data = '0;
    logic          comm_tx_complete = 1'b0;
    logic          mult_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          comm_op, comm_start, mem_we, mult_start, busy, done, error;
    logic [DW-1:0] comm_tx_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    row_transfer_sequencer #(.MATRIX_N(N), .HEADER(HEADER)) dut (
        .clk(clk), .resetn(resetn), .go(go),
        .comm_op(comm_op), .comm_start(comm_start),
        .comm_rx_complete(comm_rx_complete), .comm_rx_data(comm_rx_data),
        .comm_tx_complete(comm_tx_complete), .comm_tx_data(comm_tx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mult_start(mult_start), .mult_done(mult_done),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Row memory model: A/B region written by the DUT, C rows provided by the bench.
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] c_rows [N];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (int'(mem_addr) >= 2*N) mem_rdata <= c_rows[int'(mem_addr) - 2*N];
        else                       mem_rdata <= mem[mem_addr];
    end

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
    typedef struct { logic [DW-1:0] data; int cyc; } tx_t;
    wr_t wq[$];
    tx_t tq[$];
    int  mq[$];
    int  dq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of its expectation queue.
    wr_t mw;
    tx_t mt;
    int  mi;
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_we) begin
                if (wq.size() == 0) check(1'b0, "unexpected_mem_we", DW'(mem_addr), '0);
                else begin
                    mw = wq.pop_front();
                    check(mem_addr == mw.addr, "wr_addr", DW'(mem_addr), DW'(mw.addr));
                    check(mem_wdata == mw.data, "wr_data", mem_wdata, mw.data);
                    check(cyc == mw.cyc, "wr_cycle", DW'(cyc), DW'(mw.cyc));
                end
            end
            if (comm_start) begin
                if (tq.size() == 0) check(1'b0, "unexpected_comm_start", comm_tx_data, '0);
                else begin
                    mt = tq.pop_front();
                    check(comm_tx_data == mt.data, "tx_data", comm_tx_data, mt.data);
                    check(cyc == mt.cyc, "tx_cycle", DW'(cyc), DW'(mt.cyc));
                    check(comm_op == 1'b1, "tx_comm_op", DW'(comm_op), DW'(1));
                end
            end
            if (mult_start) begin
                if (mq.size() == 0) check(1'b0, "unexpected_mult_start", DW'(cyc), '0);
                else begin
                    mi = mq.pop_front();
                    check(cyc == mi, "mult_start_cycle", DW'(cyc), DW'(mi));
                end
            end
            if (done) begin
                if (dq.size() == 0) check(1'b0, "unexpected_done", DW'(cyc), '0);
                else begin
                    mi = dq.pop_front();
                    check(cyc == mi, "done_cycle", DW'(cyc), DW'(mi));
                    check(comm_op == 1'b0, "done_comm_op", DW'(comm_op), DW'(0));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_pkt(input logic [7:0] hdr);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*32 +: 32] = $urandom();
        p[DW-1 -: 8] = hdr;
        return p;
    endfunction

    task automatic check_all_zero(input string name);
        check({comm_op, comm_start, mem_we, mult_start, busy, done, error} == 7'b0,
              name, DW'({comm_op, comm_start, mem_we, mult_start, busy, done, error}), '0);
        check(comm_tx_data == '0, {name, "_tx_data"}, comm_tx_data, '0);
        check(mem_wdata == '0, {name, "_wdata"}, mem_wdata, '0);
        check(mem_addr == '0, {name, "_addr"}, DW'(mem_addr), '0);
    endtask

    // One job. bad_idx >= 0 gives that rx packet header bad_hdr. reset_at >= 0
    // asserts resetn while waiting for that transmission's completion.
    task automatic run_job(input int bad_idx, input logic [7:0] bad_hdr, input int reset_at);
        logic [DW-1:0] pkt;
        logic [7:0]    hdr;
        int c, m, s, t;
        for (int k = 0; k < N; k++) c_rows[k] = rand_pkt(8'($urandom()));
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        check(busy == 1'b1, "busy_after_go", DW'(busy), DW'(1));
        check(error == 1'b0, "error_cleared_by_go", DW'(error), DW'(0));
        c = 0;
        for (int i = 0; i < 2*N; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            hdr = (i == bad_idx) ? bad_hdr : 8'($urandom_range(1, N));
            pkt = rand_pkt(hdr);
            comm_rx_data = pkt;
            comm_rx_complete = 1'b1;
            c = cyc;
            if (i != bad_idx) wq.push_back('{addr: AW'(i), data: pkt, cyc: c + 1});
            if (i == 2*N-1 && i != bad_idx) mq.push_back(c + 2);
            tick();
            // A stray rx_complete here is outside RX_WAIT and must be ignored.
            if ($urandom_range(0, 1) == 1) begin
                comm_rx_data = rand_pkt(8'h01);
                comm_rx_complete = 1'b1;
            end else begin
                comm_rx_complete = 1'b0;
            end
            tick();
            comm_rx_complete = 1'b0;
            if (i == bad_idx) begin
                check(error == 1'b1, "error_after_bad_hdr", DW'(error), DW'(1));
                check(busy == 1'b0, "idle_after_error", DW'(busy), DW'(0));
                tick();
                check(error == 1'b1, "error_sticky", DW'(error), DW'(1));
                check(wq.size() == 0 && mq.size() == 0, "no_pending_after_error",
                      DW'(wq.size() + mq.size()), '0);
                return;
            end
        end
        // Now in COMPUTE; next cycle WAIT_MULT. go there must be ignored.
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        mult_done = 1'b1;
        m = cyc;
        tq.push_back('{data: c_rows[0], cyc: m + 3});
        tick();
        mult_done = 1'b0;
        s = m + 3;
        for (int k = 0; k < N; k++) begin
            while (cyc < s) tick();
            // Events that TX_WAIT must ignore.
            comm_rx_complete = 1'b1;
            comm_rx_data = rand_pkt(8'h02);
            mult_done = 1'b1;
            go = 1'($urandom_range(0, 1));
            tick();
            comm_rx_complete = 1'b0;
            mult_done = 1'b0;
            go = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            if (k == reset_at) begin
                #1;
                resetn = 1'b0;
                #1;
                check_all_zero("reset_mid_tx");
                wq.delete(); tq.delete(); mq.delete(); dq.delete();
                repeat (3) tick();
                check_all_zero("reset_held");
                resetn = 1'b1;
                return;
            end
            comm_tx_complete = 1'b1;
            t = cyc;
            if (k < N-1) tq.push_back('{data: c_rows[k+1], cyc: t + 3});
            else         dq.push_back(t + 1);
            tick();
            comm_tx_complete = 1'b0;
            s = t + 3;
        end
        tick();
        check(busy == 1'b0, "busy_low_after_done", DW'(busy), DW'(0));
        check(done == 1'b0, "done_single_pulse", DW'(done), DW'(0));
        check(wq.size() + tq.size() + mq.size() + dq.size() == 0, "queues_drained",
              DW'(wq.size() + tq.size() + mq.size() + dq.size()), '0);
    endtask

    initial begin
        tick();
        tick();
        check_all_zero("reset_state");
        resetn = 1'b1;
        tick();
        check_all_zero("idle_after_reset");
        run_job(-1, 8'h00, -1);
        run_job(-1, 8'h00, -1);
        run_job(2, 8'h00, -1);
        run_job(-1, 8'h00, -1);
        run_job(2, 8'h05, -1);
        run_job(0, 8'hFF, -1);
        run_job(2*N-1, 8'h00, -1);
        run_job(-1, 8'h00, 1);
        run_job(-1, 8'h00, -1);
        run_job(-1, 8'h00, -1);
        repeat (3) tick();
        check(wq.size() + tq.size() + mq.size() + dq.size() == 0, "final_queues_drained",
              DW'(wq.size() + tq.size() + mq.size() + dq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_transfer_sequencer.md
ROW_TRANSFER_SEQUENCER -- requirements
Module: row_transfer_sequencer

Interface
REQ-001 SHALL have parameters: MATRIX_N, default 4, square matrix size; HEADER, default 1, header bytes per row/col packet.
REQ-002 SHALL derive DW = HEADER*8 + 32*MATRIX_N (packet width) and AW = clog2(3*MATRIX_N) (memory address width).
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk input 1, rising-edge system clock; resetn input 1, async active-low reset.
REQ-004 go  input  1  starts one full job; sampled in IDLE only.
REQ-005 comm_op  output  1  comm controller mode: 0 = receive, 1 = transmit.
REQ-006 comm_start  output  1  one-cycle pulse requesting transmission of comm_tx_data.
REQ-007 comm_rx_complete  input  1  comm controller has a full received packet on comm_rx_data.
REQ-008 comm_rx_data  input  DW  received packet; header in bits [DW-1 -: 8*HEADER].
REQ-009 comm_tx_complete  input  1  comm controller has finished transmitting a packet.
REQ-010 comm_tx_data  output  DW  packet to transmit.
REQ-011 mem_we  output  1  row memory write enable; mem_addr  output  AW; mem_wdata  output  DW.
REQ-012 mem_rdata  input  DW  row memory read data, valid exactly one cycle after mem_addr is presented.
REQ-013 mult_start  output  1  one-cycle pulse starting the multiplier; mult_done  input  1  multiplier finished, C rows in memory.
REQ-014 busy  output  1; done  output  1 (one-cycle pulse); error  output  1 (sticky).

Function
REQ-015 SHALL register all outputs; memory map: A rows at 0..N-1, B cols at N..2N-1, C rows at 2N..3N-1.
REQ-016 SHALL implement states IDLE, RX_WAIT, RX_STORE, COMPUTE, WAIT_MULT, TX_FETCH, TX_LATCH, TX_WAIT, DONE, ERROR, with a packet counter cnt.
REQ-017 IDLE: go=1 -> RX_WAIT, cnt=0, error cleared, comm_op=0; else stay.
REQ-018 RX_WAIT: comm_rx_complete=1 -> capture comm_rx_data; header value 0 or >MATRIX_N -> ERROR, else RX_STORE.
REQ-019 RX_STORE: mem_we=1 for exactly one cycle, mem_addr=cnt, mem_wdata=captured packet; cnt==2N-1 -> COMPUTE, else cnt+1 -> RX_WAIT.
REQ-020 COMPUTE: mult_start=1 for one cycle -> WAIT_MULT; WAIT_MULT: mult_done=1 -> TX_FETCH with cnt=0.
REQ-021 TX_FETCH: mem_addr=2N+cnt -> TX_LATCH; TX_LATCH: comm_tx_data<=mem_rdata, comm_op=1, comm_start=1 for one cycle -> TX_WAIT.
REQ-022 TX_WAIT: comm_tx_complete=1 -> cnt==N-1 ? DONE : cnt+1 -> TX_FETCH.
REQ-023 DONE: done=1 for one cycle, comm_op=0 -> IDLE; ERROR: error=1 (held until next accepted go), comm_op=0 -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; first busy=1 the cycle after go is sampled.
REQ-025 Latency: comm_rx_complete to mem_we = 1 cycle; comm_tx_complete to next comm_start = 3 cycles.
REQ-026 go while busy, comm_rx_complete outside RX_WAIT, comm_tx_complete outside TX_WAIT, mult_done outside WAIT_MULT SHALL be ignored.
REQ-027 cnt SHALL never exceed 2N-1; mem_we SHALL never assert outside RX_STORE, and mem_addr SHALL never target 2N..3N-1 for writes.

Reset
REQ-028 resetn low SHALL immediately force IDLE, cnt=0 and all outputs 0 (comm_op, comm_start, comm_tx_data, mem_we, mem_addr, mem_wdata, mult_start, busy, done, error).
REQ-029 Reset mid-job SHALL abort without any further mem_we, comm_start or mult_start; next job restarts at address 0.

Verification
REQ-030 N=4, HEADER=1: go, 8 rx packets with header 8'h04 -> 8 mem_we pulses at addr 0..7 each 1 cycle after rx_complete, then one mult_start.
REQ-031 mult_done, memory holding C rows at 8..11 -> 4 comm_start pulses, comm_tx_data equals mem[8..11] in order, comm_op=1, then done pulse, busy=0.
REQ-032 Third rx packet header 8'h00 (also 8'h05) -> no third mem_we, error=1, IDLE; next go clears error.
REQ-033 go pulsed during WAIT_MULT and rx_complete during TX_WAIT -> no state change, no extra writes or starts.
REQ-034 resetn low during TX_WAIT after 2 packets -> all outputs 0 same cycle; after release, go restarts with first write at addr 0.
